// File: rtl/pg_1_base.sv
// Pattern generator: loads samples from host bytes into a RAM and replays them on chn_o.
// Optional macro PG_TRIGGER_EN: ARM waits for a rising edge on the synchronised trg_i.
module pg_1_base #(
   parameter int N_CH    = 8,
   parameter int N_FIFO  = 9,
   parameter int CLK_DIV = 1
)(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            rx_rd_i,
   input  logic [7:0]      rx_data_i,
   output logic [7:0]      tx_data_o,
   output logic            tx_wr_o,
   input  logic            tx_full_i,
   input  logic            trg_i,
   output logic [N_CH-1:0] chn_o,
   output logic            busy_o,
   output logic [3:0]      dbg_o
);
   localparam int          DEPTH   = 1 << N_FIFO;
   localparam int          DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [16:0] DEPTH17 = 17'(DEPTH);

   typedef enum logic [2:0] {IDLE = 3'd0, LEN_L = 3'd1, LEN_H = 3'd2, LOAD = 3'd3,
                             ARM = 3'd4, PLAY = 3'd5} state_t;
   state_t state, state_nxt;

   logic [15:0]       len_fld;
   logic [16:0]       waddr;
   logic [N_FIFO:0]   len;
   logic [N_FIFO-1:0] raddr;
   logic [DW-1:0]     div_cnt;
   logic              loaded, loop, trunc, fin, drain, rd_vld;
   logic [N_CH-1:0]   ram [DEPTH];
   logic [N_CH-1:0]   rdata;
   logic              tx_pend;
   logic [7:0]        tx_byte;

   logic       ack_req, stat_req, rd_issue, do_stop, start, arm_go, tick, last, wr_ok;
   logic [7:0] ack_byte;

`ifdef PG_TRIGGER_EN
   logic [2:0] trg_sync;
   always_ff @(posedge clk_i) begin
      if (rst_i) trg_sync <= '0;
      else       trg_sync <= {trg_sync[1:0], trg_i};
   end
   assign arm_go = trg_sync[1] & ~trg_sync[2];
`else
   logic unused_trg;
   assign unused_trg = trg_i;
   assign arm_go     = 1'b1;
`endif

   assign tick    = (div_cnt == DW'(CLK_DIV - 1));
   assign last    = (raddr == (len[N_FIFO-1:0] - N_FIFO'(1)));
   assign wr_ok   = (waddr < DEPTH17);
   assign busy_o  = (state == ARM) || (state == PLAY);
   assign tx_wr_o = tx_pend && !tx_full_i;
   assign tx_data_o = tx_byte;
   assign dbg_o   = {tx_pend, state};

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ack_req   = 1'b0;
      ack_byte  = 8'h00;
      stat_req  = 1'b0;
      rd_issue  = 1'b0;
      do_stop   = 1'b0;
      start     = 1'b0;
      case (state)
         IDLE: if (rx_rd_i) begin
            case (rx_data_i)
               8'h01: state_nxt = LEN_L;
               8'h02, 8'h03:
                  if (loaded) begin
                     state_nxt = ARM;
                     start     = 1'b1;
                  end else begin
                     ack_req  = 1'b1;
                     ack_byte = 8'hE1;
                  end
               8'h04: stat_req = 1'b1;
               8'h00: do_stop  = 1'b1;
               default: ;
            endcase
         end
         LEN_L: if (rx_rd_i) state_nxt = LEN_H;
         LEN_H: if (rx_rd_i) state_nxt = LOAD;
         LOAD: if (rx_rd_i && waddr == {1'b0, len_fld}) begin
            state_nxt = IDLE;
            ack_req   = 1'b1;
            ack_byte  = 8'hA1;
         end
         ARM, PLAY: begin
            if (rx_rd_i && rx_data_i == 8'h00) begin
               do_stop   = 1'b1;
               state_nxt = IDLE;
            end else begin
               stat_req = rx_rd_i && rx_data_i == 8'h04;
               if (state == ARM) begin
                  if (arm_go) begin
                     state_nxt = PLAY;
                     rd_issue  = 1'b1;
                  end
               end else if (drain) begin
                  // last sample has now been shown for its full hold period
                  state_nxt = IDLE;
                  ack_req   = 1'b1;
                  ack_byte  = 8'hD0;
               end else if (tick && !fin) begin
                  rd_issue = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (wr_ok && state == LOAD && rx_rd_i) ram[waddr[N_FIFO-1:0]] <= rx_data_i[N_CH-1:0];
      rdata <= ram[raddr];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         len_fld <= '0;
         waddr   <= '0;
         len     <= '0;
         raddr   <= '0;
         div_cnt <= '0;
         loaded  <= 1'b0;
         loop    <= 1'b0;
         trunc   <= 1'b0;
         fin     <= 1'b0;
         drain   <= 1'b0;
         rd_vld  <= 1'b0;
         chn_o   <= '0;
         tx_pend <= 1'b0;
         tx_byte <= '0;
      end else begin
         if (state == IDLE && rx_rd_i && rx_data_i == 8'h01) trunc <= 1'b0;
         if (state == LEN_L && rx_rd_i) len_fld[7:0] <= rx_data_i;
         if (state == LEN_H && rx_rd_i) begin
            len_fld[15:8] <= rx_data_i;
            waddr         <= '0;
         end
         if (state == LOAD && rx_rd_i) begin
            waddr <= waddr + 17'd1;
            if (!wr_ok) trunc <= 1'b1;
            if (state_nxt == IDLE) begin
               loaded <= 1'b1;
               len    <= wr_ok ? (N_FIFO+1)'(waddr + 17'd1) : (N_FIFO+1)'(DEPTH);
            end
         end
         if (start) begin
            loop  <= rx_data_i[0];
            raddr <= '0;
            fin   <= 1'b0;
            drain <= 1'b0;
         end
         rd_vld <= rd_issue;
         if (rd_issue) begin
            raddr   <= last ? '0 : raddr + N_FIFO'(1);
            div_cnt <= '0;
            if (last && !loop) fin <= 1'b1;
         end else if (!tick) begin
            div_cnt <= div_cnt + DW'(1);
         end
         if (state == PLAY && tick && fin) drain <= 1'b1;
         if (do_stop)     chn_o <= '0;
         else if (rd_vld) chn_o <= rdata;
         // single-entry Tx slot: anything queued while occupied is lost
         if (tx_wr_o) tx_pend <= 1'b0;
         if (!tx_pend) begin
            if (ack_req) begin
               tx_pend <= 1'b1;
               tx_byte <= ack_byte;
            end else if (stat_req) begin
               tx_pend <= 1'b1;
               tx_byte <= {busy_o, loop, loaded, trunc, 4'h5};
            end
         end
      end
   end
endmodule

// File: tb/tb_pg_1_base.sv
// Scoreboard bench for pg_1_base: expected Tx bytes and per-cycle chn_o values are queued.
module tb_pg_1_base;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_rd = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [7:0] tx_data;
   logic       tx_wr;
   logic       tx_full = 1'b0;
   logic       trg = 1'b0;
   logic [7:0] chn;
   logic       busy;
   logic [3:0] dbg;

   int n_chk = 0;
   int n_err = 0;
   logic [7:0] exp_tx[$];
   logic [7:0] chn_q[$];

   pg_1_base #(.N_CH(8), .N_FIFO(9), .CLK_DIV(1)) dut (
      .clk_i(clk), .rst_i(rst), .rx_rd_i(rx_rd), .rx_data_i(rx_data),
      .tx_data_o(tx_data), .tx_wr_o(tx_wr), .tx_full_i(tx_full), .trg_i(trg),
      .chn_o(chn), .busy_o(busy), .dbg_o(dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (tx_wr) begin
            chk("tx_full_wr", tx_full, 0);
            if (exp_tx.size() == 0) chk("tx_unexp", {24'h0, tx_data}, 32'h100);
            else                    chk("tx_byte", tx_data, exp_tx.pop_front());
         end
         if (chn_q.size() > 0) chk("chn", chn, chn_q.pop_front());
      end
   end

   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      rx_rd = 1'b1; rx_data = b;
      @(posedge clk); #1;
      rx_rd = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   function automatic logic [7:0] pat(input int i, input bit big);
      logic [31:0] v;
      v = i;
      if (big) return (i < 512) ? v[7:0] : 8'hEE;
      case (i % 3)
         0: return 8'hAA;
         1: return 8'hBB;
         default: return 8'hCC;
      endcase
   endfunction

   task automatic load(input logic [15:0] l, input bit big);
      exp_tx.push_back(8'hA1);
      send(8'h01); send(l[7:0]); send(l[15:8]);
      for (int i = 0; i <= int'(l); i++) send(pat(i, big));
   endtask

   task automatic wait_empty(input int bound);
      int n;
      n = 0;
      while ((exp_tx.size() != 0 || chn_q.size() != 0) && n < bound) begin
         @(posedge clk); n++;
      end
      chk("drain", exp_tx.size() + chn_q.size(), 0);
   endtask

   initial begin
      do_reset();
      @(negedge clk);
      chk("rst_chn", chn, 0);
      chk("rst_txwr", tx_wr, 0);
      chk("rst_txdata", tx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dbg", dbg, 0);

      // three-sample one-shot playback
      load(16'h0002, 1'b0);
      wait_empty(20);
      send(8'h02);
      chk("busy_arm", busy, 1);
      chk("dbg_arm", dbg, 4'h4);
      chn_q = '{8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hCC, 8'hCC};
      exp_tx.push_back(8'hD0);
      wait_empty(40);
      @(negedge clk);
      chk("busy_done", busy, 0);
      chk("hold_last", chn, 8'hCC);
      send(8'h00);
      chn_q.push_back(8'h00);
      wait_empty(10);

      // L=0 loads exactly one sample
      load(16'h0000, 1'b0);
      wait_empty(20);
      send(8'h02);
      chn_q = '{8'h00, 8'h00, 8'hAA, 8'hAA};
      exp_tx.push_back(8'hD0);
      wait_empty(40);

      // reset during LOAD leaves nothing playable
      send(8'h01); send(8'h03); send(8'h00); send(8'h11);
      do_reset();
      send(8'h02);
      exp_tx.push_back(8'hE1);
      chn_q = '{8'h00, 8'h00, 8'h00, 8'h00};
      wait_empty(20);
      send(8'h04);
      exp_tx.push_back(8'h05);
      wait_empty(20);

      // loop playback, then STOP
      load(16'h0002, 1'b0);
      wait_empty(20);
      send(8'h03);
      chn_q = '{8'h00, 8'h00};
      for (int k = 0; k < 11; k++) chn_q.push_back(pat(k, 1'b0));
      repeat (3) chn_q.push_back(8'h00);
      repeat (11) @(posedge clk);
      send(8'h00);
      wait_empty(20);
      chk("busy_stop", busy, 0);

      // oversize load is truncated to RAM depth
      do_reset();
      load(16'h0200, 1'b1);
      wait_empty(20);
      send(8'h04);
      exp_tx.push_back(8'h35);
      wait_empty(20);
      send(8'h02);
      chn_q = '{8'h00, 8'h00};
      for (int k = 0; k < 512; k++) chn_q.push_back(pat(k, 1'b1));
      chn_q.push_back(8'hFF);
      chn_q.push_back(8'hFF);
      exp_tx.push_back(8'hD0);
      wait_empty(700);

      // Tx back-pressure: ack survives, status is dropped
      do_reset();
      tx_full = 1'b1;
      load(16'h0002, 1'b0);
      send(8'h04);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("pend_full", dbg[3], 1);
      chk("txwr_full", tx_wr, 0);
      @(posedge clk); #1 tx_full = 1'b0;
      wait_empty(20);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("pend_clear", dbg[3], 0);

`ifdef PG_TRIGGER_EN
      do_reset();
      load(16'h0002, 1'b0);
      wait_empty(20);
      send(8'h02);
      for (int k = 0; k < 20; k++) chn_q.push_back(8'h00);
      wait_empty(40);
      @(negedge clk);
      chk("trg_busy", busy, 1);
      chk("trg_dbg", dbg, 4'h4);
      @(posedge clk); #1 trg = 1'b1;
      begin
         int n;
         n = 0;
         while (chn !== 8'hAA && n < 6) begin @(negedge clk); n++; end
         chk("trg_first", chn, 8'hAA);
      end
      exp_tx.push_back(8'hD0);
      wait_empty(40);
      trg = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end
endmodule
